// File: rtl/pcie_ring_dma_ctlr.sv
// pcie_ring_dma_ctlr
//   Services a host-side circular ring of fixed-size blocks. Polls the host write pointer,
//   fetches each pending block into the inbound RAM, hands it to the crypto engine, drains
//   the outbound RAM to the host output ring and publishes the updated read pointer.
//   Handles ring wrap-around, multi-block batching and bounded retry on bus errors.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   En                            enable (honoured only in IDLE, WAIT_POLL and ERR)
//   CfgPtrBase/CfgInBase/CfgOutBase  host pointer block, input ring and output ring bases
//   RdRq*                         read request channel (Valid/Addr out, Data/Ready/Err in)
//   WrRq*                         write request channel (Valid/Addr/Data out, Ready/Err in)
//   IbWrEn/IbWrAddr/IbWrData      inbound RAM write port
//   IbDataValid, IbRamValid       block-ready pulse and inbound RAM ownership to the engine
//   ObRdEn/ObRdAddr/ObRdData      outbound RAM read port (one-cycle read latency)
//   ObDataValid, ObRamValid       engine done, outbound RAM ownership
//   Err, RdPtr                    sticky fatal error, current local read pointer
module pcie_ring_dma_ctlr #(
   parameter int unsigned DATA_W       = 128,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned RAM_AW       = 8,
   parameter int unsigned RING_ENTRIES = 64,
   parameter int unsigned COUNTER_LEN  = 6,
   parameter int unsigned MAX_RETRY    = 3,
   localparam int unsigned PW          = $clog2(RING_ENTRIES) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              En,
   input  logic [63:0]       CfgPtrBase,
   input  logic [63:0]       CfgInBase,
   input  logic [63:0]       CfgOutBase,
   output logic              RdRqValid,
   output logic [63:0]       RdRqAddr,
   input  logic [DATA_W-1:0] RdRqData,
   input  logic              RdRqReady,
   input  logic              RdRqErr,
   output logic              WrRqValid,
   output logic [63:0]       WrRqAddr,
   output logic [DATA_W-1:0] WrRqData,
   input  logic              WrRqReady,
   input  logic              WrRqErr,
   output logic              IbWrEn,
   output logic [RAM_AW-1:0] IbWrAddr,
   output logic [DATA_W-1:0] IbWrData,
   output logic              IbDataValid,
   output logic              IbRamValid,
   output logic              ObRdEn,
   output logic [RAM_AW-1:0] ObRdAddr,
   input  logic [DATA_W-1:0] ObRdData,
   input  logic              ObDataValid,
   output logic              ObRamValid,
   output logic              Err,
   output logic [PW-1:0]     RdPtr
);

   localparam int unsigned     LW          = PW - 1;
   localparam int unsigned     RW          = $clog2(MAX_RETRY + 2);
   localparam logic [63:0]     BEAT_BYTES  = 64'(DATA_W / 8);
   localparam logic [63:0]     BLOCK_BYTES = 64'(BURST_LEN * DATA_W / 8);
   localparam logic [RAM_AW-1:0] LAST_BEAT = RAM_AW'(BURST_LEN - 1);

   typedef enum logic [3:0] {
      StIdle, StPoll, StCheck, StWaitPoll, StFetch,
      StHandoff, StWaitDone, StDrain, StUpdate, StErr
   } state_e;

   state_e                 state_q, state_d;
   logic [PW-1:0]          rdptr_q, rdptr_d, wrptr_q, wrptr_d;
   logic [RAM_AW-1:0]      beat_q, beat_d;
   logic [RW-1:0]          retry_q, retry_d;
   logic [COUNTER_LEN-1:0] poll_q, poll_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [63:0]            rd_addr_q, rd_addr_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [63:0]            wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]      wr_data_q, wr_data_d;
   logic                   ib_we_q, ib_we_d;
   logic [RAM_AW-1:0]      ib_waddr_q, ib_waddr_d;
   logic [DATA_W-1:0]      ib_wdata_q, ib_wdata_d;
   logic                   ob_ren_q, ob_ren_d;
   logic                   ob_dat_q, ob_dat_d;

   logic        rd_ok, rd_bad, wr_ok, wr_bad;
   logic [63:0] blk_off, beat_off;

   assign rd_ok    = rd_valid_q & RdRqReady & ~RdRqErr;
   assign rd_bad   = rd_valid_q & RdRqReady & RdRqErr;
   assign wr_ok    = wr_valid_q & WrRqReady & ~WrRqErr;
   assign wr_bad   = wr_valid_q & WrRqReady & WrRqErr;
   // Only the low pointer bits select the ring slot; the top bit is the wrap flag.
   assign blk_off  = 64'(rdptr_q[LW-1:0]) * BLOCK_BYTES;
   assign beat_off = 64'(beat_q) * BEAT_BYTES;

   always_comb begin
      state_d    = state_q;
      rdptr_d    = rdptr_q;
      wrptr_d    = wrptr_q;
      beat_d     = beat_q;
      retry_d    = retry_q;
      poll_d     = poll_q;
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      ib_we_d    = 1'b0;
      ib_waddr_d = ib_waddr_q;
      ib_wdata_d = ib_wdata_q;
      ob_ren_d   = 1'b0;
      ob_dat_d   = 1'b0;

      // Requests are launched from an idle channel, so Valid is always low for at least
      // one cycle after a completed transfer.
      case (state_q)
         StIdle: if (En) state_d = StPoll;
         StPoll: begin
            if (!rd_valid_q) begin
               rd_valid_d = 1'b1;
               rd_addr_d  = CfgPtrBase + 64'h10;
            end
            if (rd_ok) begin
               rd_valid_d = 1'b0;
               wrptr_d    = RdRqData[PW-1:0];
               state_d    = StCheck;
            end
         end
         StCheck: begin
            beat_d  = '0;
            poll_d  = '0;
            state_d = (wrptr_q == rdptr_q) ? StWaitPoll : StFetch;
         end
         StWaitPoll: begin
            poll_d = poll_q + 1'b1;
            if (!En)        state_d = StIdle;
            else if (&poll_q) state_d = StPoll;
         end
         StFetch: begin
            if (!rd_valid_q) begin
               rd_valid_d = 1'b1;
               rd_addr_d  = CfgInBase + blk_off + beat_off;
            end
            if (rd_ok) begin
               rd_valid_d = 1'b0;
               ib_we_d    = 1'b1;
               ib_waddr_d = beat_q;
               ib_wdata_d = RdRqData;
               beat_d     = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = StHandoff;
            end
         end
         StHandoff: state_d = StWaitDone;
         StWaitDone: begin
            if (ObDataValid) begin
               beat_d  = '0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            // One beat in flight at a time: RAM read, capture, then host write.
            if (!wr_valid_q && !ob_ren_q && !ob_dat_q) ob_ren_d = 1'b1;
            ob_dat_d = ob_ren_q;
            if (ob_dat_q) begin
               wr_valid_d = 1'b1;
               wr_addr_d  = CfgOutBase + blk_off + beat_off;
               wr_data_d  = ObRdData;
            end
            if (wr_ok) begin
               wr_valid_d = 1'b0;
               beat_d     = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  rdptr_d = rdptr_q + 1'b1;
                  state_d = StUpdate;
               end
            end
         end
         StUpdate: begin
            if (!wr_valid_q) begin
               wr_valid_d = 1'b1;
               wr_addr_d  = CfgPtrBase;
               wr_data_d  = DATA_W'(rdptr_q);
            end
            if (wr_ok) begin
               wr_valid_d = 1'b0;
               beat_d     = '0;
               poll_d     = '0;
               state_d    = (rdptr_q != wrptr_q) ? StFetch : StWaitPoll;
            end
         end
         StErr: begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            if (!En) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // An errored transfer keeps Valid/Addr/Data, which reissues it next cycle.
      if (rd_bad || wr_bad) begin
         if (retry_q == RW'(MAX_RETRY)) begin
            state_d    = StErr;
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            retry_d    = '0;
         end else begin
            retry_d = retry_q + 1'b1;
         end
      end else if (rd_ok || wr_ok) begin
         retry_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         rdptr_q    <= '0;
         wrptr_q    <= '0;
         beat_q     <= '0;
         retry_q    <= '0;
         poll_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         ib_we_q    <= 1'b0;
         ib_waddr_q <= '0;
         ib_wdata_q <= '0;
         ob_ren_q   <= 1'b0;
         ob_dat_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdptr_q    <= rdptr_d;
         wrptr_q    <= wrptr_d;
         beat_q     <= beat_d;
         retry_q    <= retry_d;
         poll_q     <= poll_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ib_we_q    <= ib_we_d;
         ib_waddr_q <= ib_waddr_d;
         ib_wdata_q <= ib_wdata_d;
         ob_ren_q   <= ob_ren_d;
         ob_dat_q   <= ob_dat_d;
      end
   end

   assign RdRqValid   = rd_valid_q;
   assign RdRqAddr    = rd_addr_q;
   assign WrRqValid   = wr_valid_q;
   assign WrRqAddr    = wr_addr_q;
   assign WrRqData    = wr_data_q;
   assign IbWrEn      = ib_we_q;
   assign IbWrAddr    = ib_waddr_q;
   assign IbWrData    = ib_wdata_q;
   assign IbDataValid = (state_q == StHandoff);
   assign IbRamValid  = (state_q == StHandoff) || (state_q == StWaitDone);
   assign ObRdEn      = ob_ren_q;
   assign ObRdAddr    = beat_q;
   assign ObRamValid  = (state_q == StDrain);
   assign Err         = (state_q == StErr);
   assign RdPtr       = rdptr_q;

endmodule

// File: tb/tb_pcie_ring_dma_ctlr.sv
// Directed bench for pcie_ring_dma_ctlr: host memory / bus slaves, outbound RAM model,
// transaction logs and hand-computed expectations.
module tb_pcie_ring_dma_ctlr;

   localparam int unsigned DW = 128;
   localparam int unsigned PW = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          En = 1'b0;
   logic [63:0]   CfgPtrBase = 64'h0;
   logic [63:0]   CfgInBase  = 64'h1000;
   logic [63:0]   CfgOutBase = 64'h8000;
   logic          RdRqValid;
   logic [63:0]   RdRqAddr;
   logic [DW-1:0] RdRqData = '0;
   logic          RdRqReady = 1'b0;
   logic          RdRqErr = 1'b0;
   logic          WrRqValid;
   logic [63:0]   WrRqAddr;
   logic [DW-1:0] WrRqData;
   logic          WrRqReady = 1'b0;
   logic          WrRqErr = 1'b0;
   logic          IbWrEn;
   logic [7:0]    IbWrAddr;
   logic [DW-1:0] IbWrData;
   logic          IbDataValid;
   logic          IbRamValid;
   logic          ObRdEn;
   logic [7:0]    ObRdAddr;
   logic [DW-1:0] ObRdData = '0;
   logic          ObDataValid;
   logic          ObRamValid;
   logic          Err;
   logic [PW-1:0] RdPtr;

   pcie_ring_dma_ctlr dut (
      .clk(clk), .rst(rst), .En(En),
      .CfgPtrBase(CfgPtrBase), .CfgInBase(CfgInBase), .CfgOutBase(CfgOutBase),
      .RdRqValid(RdRqValid), .RdRqAddr(RdRqAddr), .RdRqData(RdRqData),
      .RdRqReady(RdRqReady), .RdRqErr(RdRqErr),
      .WrRqValid(WrRqValid), .WrRqAddr(WrRqAddr), .WrRqData(WrRqData),
      .WrRqReady(WrRqReady), .WrRqErr(WrRqErr),
      .IbWrEn(IbWrEn), .IbWrAddr(IbWrAddr), .IbWrData(IbWrData),
      .IbDataValid(IbDataValid), .IbRamValid(IbRamValid),
      .ObRdEn(ObRdEn), .ObRdAddr(ObRdAddr), .ObRdData(ObRdData),
      .ObDataValid(ObDataValid), .ObRamValid(ObRamValid),
      .Err(Err), .RdPtr(RdPtr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Host / engine stimulus knobs
   logic [PW-1:0] host_wrptr = '0;
   logic [63:0]   err_addr = 64'hFFFF_FFFF_FFFF_FFFF;
   int            err_left = 0;
   int            wr_delay = 0;
   int            wr_wait = 0;
   logic [63:0]   hold_a;
   logic [DW-1:0] hold_d;
   logic          ob_man = 1'b0;
   logic          auto_eng = 1'b0;

   assign ObDataValid = ob_man | (auto_eng & IbRamValid);

   // Logs
   logic [63:0]   rd_q[$];
   logic [63:0]   err_q[$];
   logic [63:0]   wa_q[$];
   logic [DW-1:0] wd_q[$];
   logic [7:0]    iba_q[$];
   logic [DW-1:0] ibd_q[$];
   int            poll_t[$];
   int            ib_dv_cnt = 0;
   int            cyc = 0;

   task automatic clear_logs();
      rd_q.delete(); err_q.delete(); wa_q.delete(); wd_q.delete();
      iba_q.delete(); ibd_q.delete(); poll_t.delete();
      ib_dv_cnt = 0;
   endtask

   // Read slave: zero-wait, data is the address replicated, pointer read returns host_wrptr.
   always @(negedge clk) begin
      RdRqReady = 1'b0;
      RdRqErr   = 1'b0;
      if (RdRqValid) begin
         RdRqReady = 1'b1;
         RdRqData  = (RdRqAddr == CfgPtrBase + 64'h10) ? DW'(host_wrptr) : {RdRqAddr, RdRqAddr};
         if (RdRqAddr == err_addr && err_left > 0) begin
            RdRqErr = 1'b1;
            err_left--;
         end
      end
   end

   // Write slave with optional back-pressure; request must hold while waiting.
   always @(negedge clk) begin
      WrRqReady = 1'b0;
      WrRqErr   = 1'b0;
      if (wr_wait != 0) begin
         check("wr_valid_held", WrRqValid, 1);
         check("wr_hold_addr", WrRqAddr, hold_a);
         check("wr_hold_data", WrRqData, hold_d);
      end
      if (WrRqValid) begin
         if (wr_wait == 0) begin
            hold_a = WrRqAddr;
            hold_d = WrRqData;
         end
         if (wr_wait >= wr_delay) begin
            WrRqReady = 1'b1;
            wr_wait   = 0;
         end else begin
            wr_wait++;
         end
      end
   end

   // Outbound RAM: mem[i] = 2i, one-cycle read latency.
   always @(posedge clk) if (ObRdEn) ObRdData <= DW'(ObRdAddr) << 1;

   always @(posedge clk) begin
      if (RdRqValid && RdRqReady) begin
         if (RdRqErr) err_q.push_back(RdRqAddr);
         else begin
            rd_q.push_back(RdRqAddr);
            if (RdRqAddr == CfgPtrBase + 64'h10) poll_t.push_back(cyc);
         end
      end
      if (WrRqValid && WrRqReady && !WrRqErr) begin
         wa_q.push_back(WrRqAddr);
         wd_q.push_back(WrRqData);
      end
      if (IbWrEn) begin
         iba_q.push_back(IbWrAddr);
         ibd_q.push_back(IbWrData);
      end
      if (IbDataValid) ib_dv_cnt++;
      cyc++;
   end

   initial begin
      int vcnt;
      int npoll;

      // Reset
      repeat (5) @(negedge clk);
      check("rst_flags", {RdRqValid, WrRqValid, IbWrEn, IbDataValid, IbRamValid, ObRdEn,
                          ObRamValid, Err}, 0);
      check("rst_rdptr", RdPtr, 0);
      check("rst_addrs", {RdRqAddr, WrRqAddr}, 0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      vcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (RdRqValid || WrRqValid) vcnt++;
      end
      check("no_valid_while_disabled", vcnt, 0);

      // Empty ring: gap between poll handshakes = CHECK 1 + WAIT_POLL 64 + issue 1 + xfer 1
      clear_logs();
      En = 1'b1;
      for (int i = 0; i < 400 && poll_t.size() < 2; i++) @(negedge clk);
      check("empty_two_polls", poll_t.size() >= 2, 1);
      check("empty_poll_gap", poll_t[1] - poll_t[0], 67);
      check("empty_no_data_reads", rd_q.size(), 2);
      check("empty_no_ib_writes", iba_q.size(), 0);

      // Single block
      clear_logs();
      host_wrptr = 7'd1;
      for (int i = 0; i < 500 && ib_dv_cnt < 1; i++) @(negedge clk);
      check("blk_ib_dv_pulse", ib_dv_cnt, 1);
      check("blk_read_count", rd_q.size(), 17);
      check("blk_poll_addr", rd_q[0], 64'h10);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("blk_rd_addr%0d", i), rd_q[i+1], 64'h1000 + 64'(i) * 16);
         check($sformatf("blk_ib_addr%0d", i), iba_q[i], i);
         check($sformatf("blk_ib_data%0d", i), ibd_q[i],
               {64'h1000 + 64'(i) * 16, 64'h1000 + 64'(i) * 16});
      end
      check("blk_handoff_flags", {IbRamValid, IbDataValid, ObRamValid}, 3'b100);
      repeat (3) @(negedge clk);
      check("blk_waitdone_hold", {IbRamValid, ObRamValid, WrRqValid}, 3'b100);
      ob_man = 1'b1;
      @(negedge clk);
      ob_man = 1'b0;
      check("blk_drain_owner", {IbRamValid, ObRamValid}, 2'b01);
      for (int i = 0; i < 500 && wa_q.size() < 17; i++) @(negedge clk);
      check("blk_write_count", wa_q.size(), 17);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("blk_wr_addr%0d", i), wa_q[i], 64'h8000 + 64'(i) * 16);
         check($sformatf("blk_wr_data%0d", i), wd_q[i], 2 * i);
      end
      check("blk_ptr_addr", wa_q[16], 0);
      check("blk_ptr_data", wd_q[16], 1);
      check("blk_rdptr", RdPtr, 1);
      check("blk_ob_released", ObRamValid, 0);

      // Advance to RdPtr = 63 through batched traffic
      auto_eng   = 1'b1;
      host_wrptr = 7'd63;
      for (int i = 0; i < 20000 && RdPtr != 7'd63; i++) @(negedge clk);
      check("pre_wrap_rdptr", RdPtr, 63);

      // Wrap and batch: blocks 63 and 64 (slot 0), pointer writes 63, 64, 65
      clear_logs();
      host_wrptr = 7'd65;
      for (int i = 0; i < 2000 && wa_q.size() < 35; i++) @(negedge clk);
      check("wrap_write_count", wa_q.size(), 35);
      check("wrap_poll_first", rd_q[0], 64'h10);
      check("wrap_blk63_first", rd_q[1], 64'h4F00);
      check("wrap_blk63_last", rd_q[16], 64'h4FF0);
      check("wrap_blk64_first", rd_q[17], 64'h1000);
      check("wrap_blk64_last", rd_q[32], 64'h10F0);
      npoll = 0;
      for (int i = 0; i < rd_q.size() && i < 33; i++) if (rd_q[i] == 64'h10) npoll++;
      check("wrap_single_poll", npoll, 1);
      check("wrap_ptr63", {wa_q[0], wd_q[0][63:0]}, {64'h0, 64'd63});
      check("wrap_out63", wa_q[1], 64'hBF00);
      check("wrap_ptr64", {wa_q[17], wd_q[17][63:0]}, {64'h0, 64'd64});
      check("wrap_out64", wa_q[18], 64'h8000);
      check("wrap_ptr65", {wa_q[34], wd_q[34][63:0]}, {64'h0, 64'd65});
      check("wrap_rdptr", RdPtr, 65);

      // Back-pressure: every write held 5 cycles, exactly one accepted per beat
      clear_logs();
      wr_delay   = 5;
      host_wrptr = 7'd66;
      for (int i = 0; i < 4000 && wa_q.size() < 17; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("bp_write_count", wa_q.size(), 17);
      check("bp_first_addr", wa_q[0], 64'h8100);
      check("bp_last_data", {wa_q[15], wd_q[15][63:0]}, {64'h81F0, 64'd30});
      check("bp_ptr", wd_q[16], 66);
      wr_delay = 0;

      // Retry: three errors on beat 3 of block 66 (slot 2), then success
      clear_logs();
      err_addr   = 64'h1230;
      err_left   = 3;
      host_wrptr = 7'd67;
      for (int i = 0; i < 2000 && wa_q.size() < 17; i++) @(negedge clk);
      check("retry_err_count", err_q.size(), 3);
      check("retry_err_addr0", err_q[0], 64'h1230);
      check("retry_err_addr2", err_q[2], 64'h1230);
      check("retry_beat3_ok", rd_q[4], 64'h1230);
      check("retry_ib_count", iba_q.size(), 16);
      check("retry_no_err", Err, 0);
      check("retry_rdptr", RdPtr, 67);

      // Fatal: four consecutive errors on beat 3 of block 67 (slot 3)
      clear_logs();
      err_addr   = 64'h1330;
      err_left   = 4;
      host_wrptr = 7'd68;
      for (int i = 0; i < 2000 && !Err; i++) @(negedge clk);
      check("fatal_err", Err, 1);
      check("fatal_err_count", err_q.size(), 4);
      check("fatal_valids_low", {RdRqValid, WrRqValid}, 0);
      check("fatal_rdptr", RdPtr, 67);
      repeat (5) @(negedge clk);
      check("fatal_sticky", Err, 1);
      En = 1'b0;
      repeat (3) @(negedge clk);
      check("fatal_cleared", Err, 0);
      check("fatal_idle_valid", RdRqValid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
